// File: rtl/fu_acc_pkg.sv
// Shared types for the accumulating functional unit.
//   alu_op_e    : operation select carried on alu_sel (codes 12..15 alias ADD)
//   fsm_state_e : accumulate-mode controller states
//   ALU_SEL_W   : width of the operation select
package fu_acc_pkg;

  localparam int ALU_SEL_W = 4;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_MUL  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_MIN  = 4'd9,
    ALU_MAX  = 4'd10,
    ALU_PASS = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ACC  = 2'd1,
    ST_EMIT = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/functional_unit_acc_if.sv
// Operand/result handshake bundle for functional_unit_acc.
//   din_1, din_2 : operands A and B
//   din_v/din_r  : input valid/ready
//   dout         : registered result
//   dout_v/dout_r: output valid/ready
// master = producer of operands and consumer of results; slave = the unit.
interface functional_unit_acc_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] din_1;
  logic [DATA_WIDTH-1:0] din_2;
  logic                  din_v;
  logic                  din_r;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_v;
  logic                  dout_r;

  modport master (
    output din_1, din_2, din_v, dout_r,
    input  din_r, dout, dout_v
  );

  modport slave (
    input  din_1, din_2, din_v, dout_r,
    output din_r, dout, dout_v
  );

endinterface

// File: rtl/fu_acc_alu.sv
// Combinational ALU for functional_unit_acc.
//   i_op     : operation select (alu_op_e encoding, 12..15 behave as ADD)
//   i_a, i_b : operands
//   o_result : result truncated to DATA_WIDTH
// The multiplier is only built when FU_ACC_MUL_EN is defined; otherwise
// the MUL code returns zero and no multiplier is inferred.
module fu_acc_alu
  import fu_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [ALU_SEL_W-1:0]  i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic signed [DATA_WIDTH-1:0] w_a_s;
  logic signed [DATA_WIDTH-1:0] w_b_s;
  logic        [SHW-1:0]        w_shamt;
  logic                         w_a_lt_b;
  logic        [DATA_WIDTH-1:0] w_prod;

  assign w_a_s    = i_a;
  assign w_b_s    = i_b;
  assign w_shamt  = i_b[SHW-1:0];
  assign w_a_lt_b = (w_a_s < w_b_s);

`ifdef FU_ACC_MUL_EN
  // Low half of the product only.
  assign w_prod = i_a * i_b;
`else
  assign w_prod = '0;
`endif

  always_comb begin
    o_result = i_a + i_b;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_MUL:  o_result = w_prod;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = w_a_s >>> w_shamt;
      ALU_MIN:  o_result = w_a_lt_b ? i_a : i_b;
      ALU_MAX:  o_result = w_a_lt_b ? i_b : i_a;
      ALU_PASS: o_result = i_a;
      default:  o_result = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/functional_unit_acc.sv
// Functional unit with optional accumulation.
// feedback=0: streaming ALU, one result per accepted input, latency 1.
// feedback=1: operand B is the accumulator; acc_len inputs are folded into
//             one result (acc_len=0 counts as 1), then the accumulator is
//             reseeded from initial_value.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : din_1/din_2/din_v/din_r, dout/dout_v/dout_r handshake
//   feedback      : accumulate mode select
//   initial_value : accumulator seed
//   acc_len       : inputs per accumulated result
//   alu_sel       : operation select
//   acc_count     : inputs absorbed in the current accumulation
// Build option: FU_ACC_MUL_EN enables the multiplier in the ALU.
module functional_unit_acc
  import fu_acc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  functional_unit_acc_if.slave   bus,
  input  logic                   feedback,
  input  logic [DATA_WIDTH-1:0]  initial_value,
  input  logic [COUNT_WIDTH-1:0] acc_len,
  input  logic [ALU_SEL_W-1:0]   alu_sel,
  output logic [COUNT_WIDTH-1:0] acc_count
);

  fsm_state_e             r_state;
  fsm_state_e             w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_acc;
  logic [DATA_WIDTH-1:0]  r_dout;
  logic                   r_dout_v;
  logic [COUNT_WIDTH-1:0] r_cnt;

  logic [DATA_WIDTH-1:0]  w_b;
  logic [DATA_WIDTH-1:0]  w_alu;
  logic [COUNT_WIDTH-1:0] w_cnt_inc;
  logic [COUNT_WIDTH-1:0] w_len_eff;
  logic                   w_last;
  logic                   w_din_r;
  logic                   w_accept;
  logic                   w_consume;

  assign w_b       = feedback ? r_acc : bus.din_2;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_len_eff = (acc_len == '0) ? {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : acc_len;
  // >= rather than == so a shortened acc_len cannot make the count run away.
  assign w_last    = (w_cnt_inc >= w_len_eff);
  assign w_accept  = bus.din_v && w_din_r;
  assign w_consume = r_dout_v && bus.dout_r;

  fu_acc_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .i_op     (alu_sel),
    .i_a      (bus.din_1),
    .i_b      (w_b),
    .o_result (w_alu)
  );

  // Next state and input-ready
  always_comb begin
    w_state_nxt = r_state;
    w_din_r     = 1'b0;
    if (!feedback) begin
      w_state_nxt = ST_LOAD;
      w_din_r     = !r_dout_v || bus.dout_r;
    end else begin
      case (r_state)
        ST_LOAD: w_state_nxt = ST_ACC;
        ST_ACC: begin
          // dout_v is normally clear here; the gate only protects a result
          // left pending from streaming mode.
          w_din_r = !r_dout_v || bus.dout_r;
          if (w_accept && w_last) w_state_nxt = ST_EMIT;
        end
        ST_EMIT: if (w_consume) w_state_nxt = ST_ACC;
        default: w_state_nxt = ST_LOAD;
      endcase
    end
    if (rst) w_din_r = 1'b0;
  end

  // State, accumulator and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_LOAD;
      r_dout   <= '0;
      r_dout_v <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      // A consumed result drops valid unless a new one is written below.
      if (w_consume) r_dout_v <= 1'b0;
      if (!feedback || r_state == ST_LOAD) begin
        r_acc <= initial_value;
        r_cnt <= '0;
        if (!feedback && w_accept) begin
          r_dout   <= w_alu;
          r_dout_v <= 1'b1;
        end
      end else if (r_state == ST_ACC) begin
        if (w_accept) begin
          r_acc <= w_alu;
          r_cnt <= w_cnt_inc;
          if (w_last) begin
            r_dout   <= w_alu;
            r_dout_v <= 1'b1;
          end
        end
      end else if (w_consume) begin
        // Reseed straight into the next batch, no LOAD bubble.
        r_acc <= initial_value;
        r_cnt <= '0;
      end
    end
  end

  assign bus.din_r  = w_din_r;
  assign bus.dout   = r_dout;
  assign bus.dout_v = r_dout_v;
  assign acc_count  = r_cnt;

endmodule

// File: tb/tb_functional_unit_acc.sv
module tb_functional_unit_acc;
  import fu_acc_pkg::*;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          feedback;
  logic [DW-1:0] initial_value;
  logic [CW-1:0] acc_len;
  logic [3:0]    alu_sel;
  logic [CW-1:0] acc_count;

  always #5 clk = ~clk;

  functional_unit_acc_if #(.DATA_WIDTH(DW)) bus ();

  functional_unit_acc #(
    .DATA_WIDTH  (DW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .feedback      (feedback),
    .initial_value (initial_value),
    .acc_len       (acc_len),
    .alu_sel       (alu_sel),
    .acc_count     (acc_count)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic          m_held;
  logic [DW-1:0] m_held_val;
  logic [DW-1:0] m_exp;

`ifdef FU_ACC_MUL_EN
  localparam logic [DW-1:0] MUL_3_5 = 8'd15;
`else
  localparam logic [DW-1:0] MUL_3_5 = 8'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on every output transfer, plus hold checks.
  initial begin
    m_held = 1'b0;
    m_held_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_held = 1'b0;
      end else begin
        if (m_held) begin
          check("hold_valid", bus.dout_v, 1);
          check("hold_stable", bus.dout, m_held_val);
        end
        if (!feedback && bus.dout_v && !bus.dout_r)
          check("din_r_backpressure", bus.din_r, 0);
        if (bus.dout_v && bus.dout_r) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h expected none", bus.dout);
          end else begin
            m_exp = exp_q.pop_front();
            check("dout", bus.dout, m_exp);
          end
        end
        m_held     = bus.dout_v && !bus.dout_r;
        m_held_val = bus.dout;
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    bus.din_1 = a;
    bus.din_2 = b;
    bus.din_v = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.din_r;
      @(posedge clk);
      #1;
      n++;
    end
    bus.din_v = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got din_r 0 for %0d cycles expected accept", n);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp);
    alu_sel = op;
    exp_q.push_back(exp);
    send(a, b);
    check("latency_dout_v", bus.dout_v, 1);
    @(posedge clk); #1;
    check("dout_v_clear", bus.dout_v, 0);
  endtask

  task automatic acc_mode(input logic [3:0] op, input logic [DW-1:0] init,
                          input logic [CW-1:0] len);
    feedback = 1'b0;
    @(posedge clk); #1;
    alu_sel       = op;
    initial_value = init;
    acc_len       = len;
    feedback      = 1'b1;
    @(posedge clk); #1;
    check("acc_count_start", acc_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst           = 1'b1;
    feedback      = 1'b0;
    initial_value = '0;
    acc_len       = '0;
    alu_sel       = 4'd0;
    bus.din_1     = '0;
    bus.din_2     = '0;
    bus.din_v     = 1'b0;
    bus.dout_r    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", bus.dout, 0);
    check("rst_dout_v", bus.dout_v, 0);
    check("rst_acc_count", acc_count, 0);
    check("rst_din_r", bus.din_r, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Streaming operations
    run_op(4'd0, 8'd3, 8'd4, 8'd7);
    run_op(4'd0, 8'd200, 8'd100, 8'd44);
    run_op(4'd1, 8'd3, 8'd5, MUL_3_5);
    run_op(4'd2, 8'd10, 8'd3, 8'd7);
    run_op(4'd2, 8'd3, 8'd10, 8'hF9);
    run_op(4'd3, 8'hF0, 8'h3C, 8'h30);
    run_op(4'd4, 8'hF0, 8'h0F, 8'hFF);
    run_op(4'd5, 8'hFF, 8'h0F, 8'hF0);
    run_op(4'd6, 8'h01, 8'h0B, 8'h08);
    run_op(4'd7, 8'h80, 8'h01, 8'h40);
    run_op(4'd8, 8'h80, 8'h01, 8'hC0);
    run_op(4'd9, 8'h80, 8'h01, 8'h80);
    run_op(4'd10, 8'h80, 8'h01, 8'h01);
    run_op(4'd11, 8'h5A, 8'h11, 8'h5A);
    run_op(4'd12, 8'd1, 8'd2, 8'd3);
    run_op(4'd15, 8'd5, 8'd6, 8'd11);

    // Streaming with output held for 3 cycles
    alu_sel    = 4'd0;
    bus.dout_r = 1'b0;
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd6);
    exp_q.push_back(8'd8);
    send(8'd1, 8'd1);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 bus.dout_r = 1'b1;
      end
    join_none
    send(8'd2, 8'd2);
    send(8'd3, 8'd3);
    send(8'd4, 8'd4);
    @(posedge clk); #1;
    check("stream_drain_v", bus.dout_v, 0);

    // Accumulate: 10 + 1 + 2 + 3, then reseeded batch 10 + 4 + 5 + 6
    acc_mode(4'd0, 8'd10, 8'd3);
    exp_q.push_back(8'd16);
    send(8'd1, 8'd0);
    check("acc_count_1", acc_count, 1);
    send(8'd2, 8'd0);
    check("acc_count_2", acc_count, 2);
    send(8'd3, 8'd0);
    check("emit_dout_v", bus.dout_v, 1);
    check("emit_din_r", bus.din_r, 0);
    @(posedge clk); #1;
    check("reseed_acc_count", acc_count, 0);
    check("reseed_dout_v", bus.dout_v, 0);
    bus.dout_r = 1'b0;
    exp_q.push_back(8'd25);
    send(8'd4, 8'd0);
    send(8'd5, 8'd0);
    send(8'd6, 8'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("emit_hold_din_r", bus.din_r, 0);
      check("emit_hold_dout", bus.dout, 8'd25);
    end
    bus.dout_r = 1'b1;
    @(posedge clk); #1;
    check("batch2_acc_count", acc_count, 0);

    // acc_len = 0 behaves as 1: SUB 8 - 5 per input
    acc_mode(4'd2, 8'd5, 8'd0);
    repeat (3) begin
      exp_q.push_back(8'd3);
      send(8'd8, 8'd0);
    end
    @(posedge clk); #1;

    // Reset after 2 of 4 absorbed
    acc_mode(4'd0, 8'd10, 8'd4);
    send(8'd1, 8'd0);
    send(8'd2, 8'd0);
    check("pre_rst_acc_count", acc_count, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_dout_v", bus.dout_v, 0);
    check("mid_rst_acc_count", acc_count, 0);
    exp_q.push_back(8'd20);
    send(8'd1, 8'd0);
    send(8'd2, 8'd0);
    send(8'd3, 8'd0);
    send(8'd4, 8'd0);

    feedback = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/functional_unit_acc.md
FUNCTIONAL_UNIT_ACC -- requirements
Module: functional_unit_acc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (>= 8).
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, accumulation-length counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports din_1, din_2  input  DATA_WIDTH  operands A and B.
REQ-006 SHALL have ports din_v input 1 and din_r output 1: input handshake.
REQ-007 SHALL have ports dout output DATA_WIDTH, dout_v output 1, dout_r input 1: output handshake.
REQ-008 SHALL have port feedback  input  1  selects accumulate mode.
REQ-009 SHALL have port initial_value  input  DATA_WIDTH  accumulator seed.
REQ-010 SHALL have port acc_len  input  COUNT_WIDTH  inputs per accumulated result.
REQ-011 SHALL have port alu_sel  input  4  operation select.
REQ-012 SHALL have port acc_count  output  COUNT_WIDTH  inputs absorbed in current accumulation.

Function
REQ-013 alu_sel SHALL encode: 0 ADD, 1 MUL, 2 SUB (A-B), 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 signed MIN, 10 signed MAX, 11 PASS A; 12-15 SHALL behave as ADD.
REQ-014 Results SHALL be truncated to DATA_WIDTH (mod 2^DATA_WIDTH); MUL keeps low half; shift amount is B[$clog2(DATA_WIDTH)-1:0].
REQ-015 Operand B SHALL be din_2 when feedback=0 and the accumulator register when feedback=1.
REQ-016 dout/dout_v SHALL be a registered output; while dout_v=1 and dout_r=0, dout SHALL hold stable.
REQ-017 Mode feedback=0: din_r = !dout_v || dout_r; accepted transfer (din_v && din_r) SHALL present ALU result on dout with dout_v=1 the next cycle (latency 1, one result per cycle sustained).
REQ-018 Mode feedback=0: dout_v SHALL clear the cycle after a consumed output (dout_v && dout_r) with no new accepted input.
REQ-019 Mode feedback=1 SHALL use FSM states LOAD, ACC, EMIT; feedback=0 SHALL force LOAD.
REQ-020 LOAD: din_r=0; accumulator <= initial_value, acc_count <= 0; next state ACC.
REQ-021 ACC: din_r=1; each accepted input: accumulator <= ALU(din_1, accumulator), acc_count++.
REQ-022 ACC: when accepted input makes acc_count+1 == acc_len, SHALL write the result to dout, set dout_v=1, go EMIT; acc_len=0 SHALL be treated as 1.
REQ-023 EMIT: din_r=0; on dout_r=1 SHALL clear dout_v, reseed accumulator from initial_value, zero acc_count, return to ACC in the same edge (no LOAD bubble).
REQ-024 Deasserting feedback mid-accumulation SHALL discard the partial result; a pending dout SHALL remain valid until consumed.
REQ-025 Config inputs (alu_sel, initial_value, acc_len) SHALL be sampled every cycle; changes only guaranteed safe in LOAD or feedback=0.

Reset
REQ-026 rst=1 SHALL set dout=0, dout_v=0, accumulator=0, acc_count=0, state LOAD.
REQ-027 din_r SHALL be 0 during reset; reset mid-accumulation or mid-EMIT SHALL drop all in-flight data.

Configuration
REQ-028 Macro FU_ACC_MUL_EN SHALL compile in the multiplier; defined: MUL per REQ-013.
REQ-029 FU_ACC_MUL_EN undefined: no multiplier inferred; alu_sel=1 SHALL yield 0.

Structure
REQ-030 Package fu_acc_pkg SHALL hold the alu_sel enum (alu_op_e) and the FSM state enum.
REQ-031 Combinational ALU SHALL be sub-module fu_acc_alu (DATA_WIDTH param, op, A, B -> result).

Verification
REQ-032 feedback=0, ADD, 3+4, dout_r=1 -> dout=7, dout_v=1 one cycle after accept.
REQ-033 feedback=0, stream 4 inputs, dout_r low 3 cycles -> din_r=0 while held, dout stable, no loss/duplication.
REQ-034 feedback=1, ADD, initial_value=10, acc_len=3, inputs 1,2,3 -> single dout=16, then next batch reseeds to 10.
REQ-035 feedback=1, acc_len=0, SUB, initial 5, input 8 -> dout=3 per input (len treated as 1).
REQ-036 DATA_WIDTH=8: ADD 200+100 -> 44; SRA 0x80 by 1 -> 0xC0; MIN(0x80,0x01) -> 0x80.
REQ-037 rst pulse mid-accumulation (2 of 4 absorbed) -> dout_v=0, acc_count=0, restart from initial_value.
